// File: rtl/o_feature_store.sv
// Output feature store: reads a burst from the on-chip output buffer through a
// 2-entry skid FIFO and writes it to external memory over a valid/ready port.
// state  | meaning
// S_IDLE | waiting for store_enable
// S_RUN  | issuing buffer reads and draining the FIFO to external memory
// S_DONE | one-cycle store_done pulse
module o_feature_store #(
  parameter int DATA_W          = 128,
  parameter int BUF_ADDR_W      = 15,
  parameter int EXT_ADDR_W      = 16,
  parameter int OUT_ADDR_OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  store_enable,
  input  logic [7:0]            store_type,
  input  logic [7:0]            src_addr,
  input  logic [15:0]           dst_addr,
  input  logic [7:0]            mem_sel,
  input  logic [7:0]            store_counter,
  output logic                  buf_rd_en,
  output logic [BUF_ADDR_W-1:0] buf_rd_addr,
  output logic                  buf_mem_select,
  input  logic [DATA_W-1:0]     buf_rd_data,
  output logic                  ext_wr_en,
  output logic [EXT_ADDR_W-1:0] ext_wr_addr,
  output logic [DATA_W-1:0]     ext_wr_data,
  input  logic                  ext_wr_ready,
  output logic                  busy,
  output logic                  store_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            reads_left_q, reads_left_d;
  logic [BUF_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [EXT_ADDR_W-1:0] ext_ptr_q, ext_ptr_d;
  logic                  mem_sel_q, mem_sel_d;
  logic [7:0]            store_type_q, store_type_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_W-1:0]     fifo_q [2];
  logic [DATA_W-1:0]     fifo_d [2];
  logic                  fifo_wr_q, fifo_wr_d;
  logic                  fifo_rd_q, fifo_rd_d;
  logic [1:0]            fifo_occ_q, fifo_occ_d;
  logic                  pop;
  logic                  rd_issue;
  logic                  unused_ok;

  assign unused_ok = &{1'b0, store_type_q, mem_sel[7:1]};

  always_comb begin
    state_d      = state_q;
    reads_left_d = reads_left_q;
    rd_ptr_d     = rd_ptr_q;
    ext_ptr_d    = ext_ptr_q;
    mem_sel_d    = mem_sel_q;
    store_type_d = store_type_q;
    fifo_d       = fifo_q;
    fifo_wr_d    = fifo_wr_q;
    fifo_rd_d    = fifo_rd_q;

    pop = (fifo_occ_q != 2'd0) && ext_wr_ready;
    // Count the read in flight and credit a same-cycle pop so a stream keeps 1 beat/cycle.
    rd_issue = (state_q == S_RUN) && (reads_left_q != 8'd0) &&
               (({1'b0, fifo_occ_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
    inflight_d = rd_issue;

    if (rd_issue) begin
      reads_left_d = reads_left_q - 8'd1;
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end
    if (inflight_q) begin
      fifo_d[fifo_wr_q] = buf_rd_data;
      fifo_wr_d         = ~fifo_wr_q;
    end
    if (pop) begin
      fifo_rd_d = ~fifo_rd_q;
      ext_ptr_d = ext_ptr_q + 1'b1;
    end
    fifo_occ_d = fifo_occ_q + {1'b0, inflight_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (store_enable) begin
          state_d      = S_RUN;
          reads_left_d = (store_counter == 8'd0) ? 8'd1 : store_counter;
          rd_ptr_d     = {{(BUF_ADDR_W-8){1'b0}}, src_addr};
          ext_ptr_d    = EXT_ADDR_W'(dst_addr) + EXT_ADDR_W'(OUT_ADDR_OFFSET);
          mem_sel_d    = mem_sel[0];
          store_type_d = store_type;
        end
      end
      S_RUN: begin
        if ((reads_left_q == 8'd0) && !inflight_q && (fifo_occ_d == 2'd0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      reads_left_q <= '0;
      rd_ptr_q     <= '0;
      ext_ptr_q    <= '0;
      mem_sel_q    <= 1'b0;
      store_type_q <= '0;
      inflight_q   <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_rd_q    <= 1'b0;
      fifo_occ_q   <= '0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      reads_left_q <= reads_left_d;
      rd_ptr_q     <= rd_ptr_d;
      ext_ptr_q    <= ext_ptr_d;
      mem_sel_q    <= mem_sel_d;
      store_type_q <= store_type_d;
      inflight_q   <= inflight_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_occ_q   <= fifo_occ_d;
      for (int i = 0; i < 2; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign buf_rd_en      = rd_issue;
  assign buf_rd_addr    = rd_ptr_q;
  assign buf_mem_select = mem_sel_q;
  assign ext_wr_en      = (fifo_occ_q != 2'd0);
  assign ext_wr_addr    = ext_ptr_q;
  assign ext_wr_data    = (fifo_occ_q != 2'd0) ? fifo_q[fifo_rd_q] : '0;
  assign busy           = (state_q != S_IDLE);
  assign store_done     = (state_q == S_DONE);

  // Read issue is throttled so returning data always has a free FIFO slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !((fifo_occ_q == 2'd2) && inflight_q && !pop));

endmodule
